mem_seg: RTL and testbench

- MEM stage of the 5-stage pipeline, directly downstream of the EX stage.
- Latches the EX outputs (ALU result, B operand, IR, branch condition) and performs word loads/stores on a local data memory with configurable wait states.
- Resolves branches for the IF stage and presents ALU result, load data (LMD) and IR to the WB stage.

---
 rtl/mem_seg_pkg.sv | 27 ++
 rtl/mem_seg_data_mem.sv | 24 ++
 rtl/mem_seg.sv | 106 ++++++++++
 tb/tb_mem_seg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_seg_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, FSM encoding, address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_seg_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQZ = 6'h04;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Everything latched from EX in one bundle
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] b;
    logic        cond;
  } ex_lat_t;

  // Word index of a byte address; callers keep only the low log2(DEPTH) bits,
  // so addresses wrap modulo the memory depth.
  function automatic logic [31:0] addr_idx(input logic [31:0] alu);
    return {2'b00, alu[31:2]};
  endfunction

endpackage

// File: rtl/mem_seg_data_mem.sv
// Local data memory: DEPTH x 32 words, write on falling clk edge, combinational read.
// Latency: write visible after the falling edge it is taken on; read is same-cycle.
// Backpressure: none; a write is taken on every edge where we is high.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Store port, aligned with the pipeline's falling-edge update
  always_ff @(negedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_seg.sv
// MEM stage: latches EX results, performs word LW/SW with wait states, resolves BEQZ.
// Latency: outputs one falling edge after latch; LW/SW occupy the stage MEM_LAT+1 cycles.
// Backpressure: stall is high in wait states; EX inputs are ignored until it drops.
module mem_seg
  import mem_seg_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] ALUi,
  input  logic [31:0] Bi,
  input  logic        condi,
  output logic [31:0] IRo,
  output logic [31:0] ALUo,
  output logic [31:0] LMDo,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        stall,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  ex_lat_t       lat_q;
  logic [31:0]   lmd_q;
  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;

  logic [5:0]    op;
  logic [5:0]    op_in;
  logic          is_ld;
  logic          is_st;
  logic          is_mem;
  logic          mis;
  logic          do_acc;
  logic          we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   rdata;

  assign op     = lat_q.ir[31:26];
  assign op_in  = IRi[31:26];
  assign is_ld  = (op == OP_LW);
  assign is_st  = (op == OP_SW);
  assign is_mem = is_ld || is_st;
  assign mis    = is_mem && (lat_q.alu[1:0] != 2'b00);

  assign mem_addr = AW'(addr_idx(lat_q.alu));

  // Pick the edge on which the latched access takes effect: with no wait states it is
  // the edge after latching (while still IDLE), otherwise the last wait edge.
  always_comb begin
    do_acc = 1'b0;
    if (MEM_LAT == 0) do_acc = (state_q == IDLE) && is_mem;
    else              do_acc = (state_q == WAIT) && (cnt_q == CW'(1));
  end

  // Reset on the same edge suppresses a store that would otherwise complete
  assign we = do_acc && is_st && !mis && rst;

  data_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (mem_addr),
    .wdata (lat_q.b),
    .rdata (rdata)
  );

  // Stage registers, load data and wait-state FSM, all on the falling edge
  always_ff @(negedge clk) begin
    if (!rst) begin
      lat_q   <= '0;
      lmd_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      if (do_acc && is_ld) lmd_q <= mis ? 32'h0 : rdata;
      case (state_q)
        IDLE: begin
          lat_q <= '{ir: IRi, alu: ALUi, b: Bi, cond: condi};
          if ((MEM_LAT > 0) && ((op_in == OP_LW) || (op_in == OP_SW))) begin
            state_q <= WAIT;
            cnt_q   <= CW'(MEM_LAT);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IRo       = lat_q.ir;
  assign ALUo      = lat_q.alu;
  assign br_target = lat_q.alu;
  assign LMDo      = lmd_q;
  assign br_taken  = (op == OP_BEQZ) && lat_q.cond;
  assign stall     = (state_q == WAIT);
  assign misalign  = mis;

endmodule

// File: tb/tb_mem_seg.sv
// Self-checking bench for mem_seg: directed scenarios plus random instruction stream.
// Latency: drives EX inputs between edges, samples on the rising edge (state moves on falling).
// Backpressure: each issued LW/SW is followed by its wait cycles before the next issue.
module tb_mem_seg;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] BEQZ = 6'h04;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic [31:0] IRi, ALUi, Bi;
  logic        condi;
  logic [31:0] IRo, ALUo, LMDo, br_target;
  logic        br_taken, stall, misalign;

  mem_seg #(.DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .IRi       (IRi),
    .ALUi      (ALUi),
    .Bi        (Bi),
    .condi     (condi),
    .IRo       (IRo),
    .ALUo      (ALUo),
    .LMDo      (LMDo),
    .br_taken  (br_taken),
    .br_target (br_target),
    .stall     (stall),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural memory image and the last loaded word
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_lmd = 32'h0;
  // Access deferred to the next edge when there are no wait states
  bit          pend_vld = 1'b0;
  logic [31:0] pend_ir, pend_alu, pend_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mem_op(input logic [31:0] ir);
    logic [5:0] o;
    o = ir[31:26];
    return (o == LW) || (o == SW);
  endfunction

  // Architectural effect of one finished LW/SW
  task automatic complete(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b);
    logic [5:0] o;
    bit aligned;
    int idx;
    o = ir[31:26];
    aligned = (alu % 4) == 0;
    idx = int'((alu / 4) % DEPTH);
    if (o == SW && aligned) ref_mem[idx] = b;
    if (o == LW) ref_lmd = aligned ? ref_mem[idx] : 32'h0;
  endtask

  task automatic garble_inputs();
    IRi = $urandom; ALUi = $urandom; Bi = $urandom; condi = 1'($urandom_range(0, 1));
  endtask

  // Present one instruction, then check the stage through its whole occupancy
  task automatic issue(input logic [31:0] ir, input logic [31:0] alu,
                       input logic [31:0] b, input logic cond);
    bit mem, mis, taken;
    IRi = ir; ALUi = alu; Bi = b; condi = cond;
    @(negedge clk);
    if (pend_vld) begin
      complete(pend_ir, pend_alu, pend_b);
      pend_vld = 1'b0;
    end
    @(posedge clk);
    mem   = is_mem_op(ir);
    mis   = mem && ((alu % 4) != 0);
    taken = (ir[31:26] == BEQZ) && cond;
    check("iro", IRo, ir);
    check("aluo", ALUo, alu);
    check("br_target", br_target, alu);
    check("br_taken", 32'(br_taken), 32'(taken));
    check("misalign", 32'(misalign), 32'(mis));
    check("stall_first", 32'(stall), 32'(mem && (LAT > 0)));
    check("lmd_before", LMDo, ref_lmd);
    if (mem && LAT == 0) begin
      pend_vld = 1'b1; pend_ir = ir; pend_alu = alu; pend_b = b;
    end else if (mem) begin
      for (int k = 1; k <= LAT; k++) begin
        garble_inputs();
        @(negedge clk);
        if (k == LAT) complete(ir, alu, b);
        @(posedge clk);
        check("stall_wait", 32'(stall), 32'(k < LAT));
        check("iro_hold", IRo, ir);
        check("aluo_hold", ALUo, alu);
        check("lmd_wait", LMDo, ref_lmd);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_iro"}, IRo, 32'h0);
    check({tag, "_aluo"}, ALUo, 32'h0);
    check({tag, "_lmd"}, LMDo, 32'h0);
    check({tag, "_tgt"}, br_target, 32'h0);
    check({tag, "_flags"}, {29'h0, br_taken, stall, misalign}, 32'h0);
  endtask

  initial begin
    logic [31:0] alu, ir;
    int sel;

    // Reset held for two edges with busy inputs
    rst = 1'b0;
    IRi = {SW, 26'h155}; ALUi = 32'h44; Bi = 32'h1234_5678; condi = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    check_cleared("reset");
    rst = 1'b1;

    // Bring every word to a known value
    for (int i = 0; i < DEPTH; i++) issue({SW, 26'h0}, 32'(i * 4), 32'h0, 1'b0);

    // Store then load through the wait states
    issue({SW, 26'h0}, 32'h10, 32'hDEAD_BEEF, 1'b0);
    issue({LW, 26'h0}, 32'h10, 32'h0, 1'b0);
    check("lw_after_sw", LMDo, 32'hDEAD_BEEF);

    // Branch resolution, taken and not taken
    issue({BEQZ, 26'h0}, 32'h40, 32'h0, 1'b1);
    check("beqz_taken", 32'(br_taken), 32'h1);
    issue({BEQZ, 26'h0}, 32'h40, 32'h0, 1'b0);
    check("beqz_not_taken", 32'(br_taken), 32'h0);

    // Misaligned store leaves word 4 alone; misaligned load yields 0
    issue({SW, 26'h0}, 32'h12, 32'h0BAD_0BAD, 1'b0);
    issue({LW, 26'h0}, 32'h10, 32'h0, 1'b0);
    check("mis_sw_no_write", LMDo, 32'hDEAD_BEEF);
    issue({LW, 26'h0}, 32'h12, 32'h0, 1'b0);
    check("mis_lw_zero", LMDo, 32'h0);

    // Address wraps modulo DEPTH words
    issue({SW, 26'h0}, 32'h400, 32'h5, 1'b0);
    issue({LW, 26'h0}, 32'h0, 32'h0, 1'b0);
    check("wrap_lw", LMDo, 32'h5);

    // Reset during the first wait cycle cancels the store
    IRi = {SW, 26'h0}; ALUi = 32'h20; Bi = 32'h7; condi = 1'b0;
    @(negedge clk);
    @(posedge clk);
    check("midwait_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    check_cleared("midwait_rst");
    ref_lmd  = 32'h0;
    pend_vld = 1'b0;
    rst = 1'b1;
    issue({LW, 26'h0}, 32'h20, 32'h0, 1'b0);
    check("midwait_old_val", LMDo, 32'h0);

    // Random instruction stream against the reference
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ir = {LW, 26'($urandom)};
        1:       ir = {SW, 26'($urandom)};
        2:       ir = {BEQZ, 26'($urandom)};
        default: ir = $urandom;
      endcase
      alu = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) alu = alu + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) alu = alu + 32'($urandom_range(1, 7) * DEPTH * 4);
      issue(ir, alu, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
